// File: rtl/ic_ffbank.sv
`default_nettype none
// ============================================================================
// Module   : ic_ffbank
// Purpose  : Bank of N single-bit flip-flop channels. Each channel selects
//            its own mode: D, T, JK or shift. A saturating detector counts
//            consecutive edges at which the next state equals a pattern.
//            Z asserts once that count reaches HOLD.
// Revision : 1.0 - initial release
// ============================================================================
module ic_ffbank #(
   parameter int N    = 4,
   parameter int HOLD = 3,
   parameter int CW   = $clog2(HOLD + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [2*N-1:0]  mode,
   input  logic [N-1:0]    a,
   input  logic [N-1:0]    b,
   input  logic [N-1:0]    pattern,
   output logic [N-1:0]    Q,
   output logic [CW-1:0]   mcnt,
   output logic            Z
);

   localparam logic [1:0]    c_MODE_D  = 2'b00;
   localparam logic [1:0]    c_MODE_T  = 2'b01;
   localparam logic [1:0]    c_MODE_JK = 2'b10;
   localparam logic [1:0]    c_MODE_SH = 2'b11;
   localparam logic [CW-1:0] c_HOLD    = CW'(HOLD);

   logic [N-1:0]  r_q;
   logic [CW-1:0] r_mcnt;
   logic [N-1:0]  w_qn;
   logic [N-1:0]  w_shin;
   logic [CW-1:0] w_mcnt_nxt;
   logic          w_match;

   // The shift source is the pre-edge state of the lower neighbour. Channel 0
   // takes a[0]. Building it from r_q means a shift chain moves exactly one
   // place per edge, whatever mode each neighbour uses.
   generate
      if (N == 1) begin : g_shin_single
         assign w_shin = a[0];
      end else begin : g_shin_chain
         assign w_shin = {r_q[N-2:0], a[0]};
      end
   endgenerate

   // Next-state logic for every channel. When en is low, the whole bank holds.
   always_comb begin
      w_qn = r_q;
      if (en) begin
         for (int i = 0; i < N; i++) begin
            case (mode[2*i +: 2])
               c_MODE_D:  w_qn[i] = a[i];
               c_MODE_T:  w_qn[i] = r_q[i] ^ a[i];
               c_MODE_JK: begin
                  case ({a[i], b[i]})
                     2'b00:   w_qn[i] = r_q[i];
                     2'b01:   w_qn[i] = 1'b0;
                     2'b10:   w_qn[i] = 1'b1;
                     default: w_qn[i] = ~r_q[i];
                  endcase
               end
               default:   w_qn[i] = w_shin[i];
            endcase
         end
      end
   end

   // The match is judged on the value Q is about to take, not on the current Q.
   // The counter saturates at HOLD so that it never wraps back to zero.
   always_comb begin
      w_match    = (w_qn == pattern);
      w_mcnt_nxt = '0;
      if (w_match) begin
         w_mcnt_nxt = (r_mcnt == c_HOLD) ? c_HOLD : r_mcnt + CW'(1);
      end
   end

   // Flip-flop bank state. Reset is asynchronous and clears it at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else begin
         r_q <= w_qn;
      end
   end

   // Match counter. It runs every edge, even when the bank is held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcnt <= '0;
      end else begin
         r_mcnt <= w_mcnt_nxt;
      end
   end

   assign Q    = r_q;
   assign mcnt = r_mcnt;
   // Z depends only on a register, so it has no input-to-output path.
   assign Z    = (r_mcnt == c_HOLD);

endmodule
`default_nettype wire

// File: tb/tb_ic_ffbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_ic_ffbank
// Purpose  : Self-checking bench for ic_ffbank (N=4, HOLD=3). It runs
//            directed vectors from a table, some hand-written reset
//            sequences, and randomized traffic compared against a
//            behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ic_ffbank;

   localparam int N    = 4;
   localparam int HOLD = 3;
   localparam int CW   = 2;

   logic            clk;
   logic            rst_n;
   logic            en;
   logic [2*N-1:0]  mode;
   logic [N-1:0]    a;
   logic [N-1:0]    b;
   logic [N-1:0]    pattern;
   logic [N-1:0]    Q;
   logic [CW-1:0]   mcnt;
   logic            Z;

   int pass_cnt = 0;
   int total    = 0;

   ic_ffbank #(.N(N), .HOLD(HOLD)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mode    (mode),
      .a       (a),
      .b       (b),
      .pattern (pattern),
      .Q       (Q),
      .mcnt    (mcnt),
      .Z       (Z)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string      name;
      logic       en;
      logic [7:0] mode;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] pat;
      logic [3:0] eq;
      logic [1:0] em;
      logic       ez;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string nm, input logic e, input logic [7:0] md,
                      input logic [3:0] av, input logic [3:0] bv,
                      input logic [3:0] pv, input logic [3:0] eq,
                      input logic [1:0] em, input logic ez);
      vec_t v;
      v.name = nm; v.en = e; v.mode = md; v.a = av; v.b = bv; v.pat = pv;
      v.eq = eq; v.em = em; v.ez = ez;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic [3:0] eq,
                        input logic [1:0] em, input logic ez);
      total++;
      if (Q === eq && mcnt === em && Z === ez) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got Q=%b mcnt=%0d Z=%b, expected Q=%b mcnt=%0d Z=%b",
                  nm, Q, mcnt, Z, eq, em, ez);
      end
   endtask

   // Reference model: each channel is worked out from its mode rule on plain
   // integers, and the count follows the saturating-match rule.
   function automatic logic [3:0] model_next(input logic [3:0] q, input logic e,
                                             input logic [7:0] md,
                                             input logic [3:0] av,
                                             input logic [3:0] bv);
      logic [3:0] r;
      r = q;
      if (e) begin
         for (int i = 0; i < N; i++) begin
            int m;
            m = int'(md[2*i +: 2]);
            if (m == 0)      r[i] = av[i];
            else if (m == 1) r[i] = q[i] ^ av[i];
            else if (m == 2) begin
               if (av[i] && bv[i]) r[i] = ~q[i];
               else if (av[i])     r[i] = 1'b1;
               else if (bv[i])     r[i] = 1'b0;
               else                r[i] = q[i];
            end else begin
               r[i] = (i == 0) ? av[0] : q[i-1];
            end
         end
      end
      return r;
   endfunction

   localparam logic [7:0] ALL_D  = 8'h00;
   localparam logic [7:0] ALL_T  = 8'h55;
   localparam logic [7:0] ALL_JK = 8'hAA;
   localparam logic [7:0] ALL_SH = 8'hFF;
   localparam logic [7:0] MIXED  = 8'b00_01_10_11; // ch3 D, ch2 T, ch1 JK, ch0 shift

   initial begin
      logic [3:0] mq;
      int         mc;
      logic [3:0] eq;
      int         ec;

      // Directed table. Each row is applied on one rising edge, in order.
      add("d_load",      1, ALL_D,  4'b1010, 4'b0000, 4'b1111, 4'b1010, 0, 0);
      add("d_hold1",     0, ALL_D,  4'b0101, 4'b0000, 4'b1111, 4'b1010, 0, 0);
      add("d_hold2",     0, ALL_D,  4'b0101, 4'b0000, 4'b1111, 4'b1010, 0, 0);
      add("t_step1",     1, ALL_T,  4'b0011, 4'b0000, 4'b1111, 4'b1001, 0, 0);
      add("t_step2",     1, ALL_T,  4'b0011, 4'b0000, 4'b1111, 4'b1010, 0, 0);
      add("d_clear",     1, ALL_D,  4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
      add("jk_all",      1, ALL_JK, 4'b1100, 4'b1010, 4'b1111, 4'b1100, 0, 0);
      add("d_seed",      1, ALL_D,  4'b0001, 4'b0000, 4'b1111, 4'b0001, 0, 0);
      add("sh_1",        1, ALL_SH, 4'b0000, 4'b0000, 4'b1111, 4'b0010, 0, 0);
      add("sh_2",        1, ALL_SH, 4'b0000, 4'b0000, 4'b1111, 4'b0100, 0, 0);
      add("sh_3",        1, ALL_SH, 4'b0000, 4'b0000, 4'b1111, 4'b1000, 0, 0);
      add("sh_4",        1, ALL_SH, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 0, 0);
      add("d_0110",      1, ALL_D,  4'b0110, 4'b0000, 4'b1111, 4'b0110, 0, 0);
      add("mixed",       1, MIXED,  4'b1011, 4'b0010, 4'b1111, 4'b1101, 0, 0);
      add("match_1",     1, ALL_D,  4'b0110, 4'b0000, 4'b0110, 4'b0110, 1, 0);
      add("match_2",     1, ALL_D,  4'b0110, 4'b0000, 4'b0110, 4'b0110, 2, 0);
      add("match_3",     1, ALL_D,  4'b0110, 4'b0000, 4'b0110, 4'b0110, 3, 1);
      add("match_sat",   1, ALL_D,  4'b0110, 4'b0000, 4'b0110, 4'b0110, 3, 1);
      add("match_en0",   0, ALL_D,  4'b0000, 4'b0000, 4'b0110, 4'b0110, 3, 1);
      add("match_break", 1, ALL_D,  4'b0111, 4'b0000, 4'b0110, 4'b0111, 0, 0);

      // Reset and initial state. Z stays low even though pattern=0 matches Q.
      rst_n = 1'b0; en = 1'b0; mode = '0; a = '0; b = '0; pattern = '0;
      #1;
      check("reset_init", 4'b0000, 2'd0, 1'b0);
      #1;
      pattern = 4'b1111;
      rst_n   = 1'b1;

      foreach (vecs[k]) begin
         @(negedge clk);
         en = vecs[k].en; mode = vecs[k].mode; a = vecs[k].a; b = vecs[k].b;
         pattern = vecs[k].pat;
         @(posedge clk);
         #1;
         check(vecs[k].name, vecs[k].eq, vecs[k].em, vecs[k].ez);
      end

      // Off-edge asynchronous reset while Z is high.
      @(negedge clk);
      en = 1'b1; mode = ALL_D; a = 4'b1010; pattern = 4'b1010;
      repeat (3) @(posedge clk);
      #1;
      check("pre_areset", 4'b1010, 2'd3, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_mid", 4'b0000, 2'd0, 1'b0);
      @(posedge clk);
      #1;
      check("areset_hold", 4'b0000, 2'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic against the model. About half the cycles aim the
      // pattern at the predicted next state, so match streaks really occur.
      mq = '0;
      mc = 0;
      for (int n = 0; n < 400; n++) begin
         if (n != 0) @(negedge clk);
         if ($urandom_range(0, 39) == 0) begin
            #1;
            rst_n = 1'b0;
            #1;
            check("rand_areset", 4'b0000, 2'd0, 1'b0);
            rst_n = 1'b1;
            mq = '0;
            mc = 0;
         end
         en   = ($urandom_range(0, 4) != 0);
         mode = 8'($urandom);
         a    = 4'($urandom);
         b    = 4'($urandom);
         eq   = model_next(mq, en, mode, a, b);
         pattern = ($urandom_range(0, 1) == 1) ? eq : 4'($urandom);
         ec   = (eq == pattern) ? ((mc < HOLD) ? mc + 1 : HOLD) : 0;
         @(posedge clk);
         #1;
         check("random", eq, 2'(ec), (ec == HOLD));
         mq = eq;
         mc = ec;
      end

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   // Safety net so the run always ends, even if the flow above stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/ic_ffbank.md
# ic_ffbank

Parametrised successor to the two-flip-flop lab chip. `ic_ffbank` is a bank of N single-bit flip-flop channels, each selecting its own mode: D, T, JK or shift. It adds a pattern-match detector that asserts `Z` after Q has equalled a programmable pattern for HOLD consecutive clock edges. It sits as a standalone lab IC driven directly by a testbench with the usual 10 ns clock.

## Interface

- `N`, 4, number of flip-flop channels (≥1)
- `HOLD`, 3, consecutive matching edges required before `Z` asserts (≥1)
- `CW`, $clog2(HOLD+1), width of the match counter (derived; do not override)

Ports:

- `clk` input 1: single clock; all state updates on the rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `en` input 1: update enable for the Q bank; 0 means all channels hold
- `mode` input 2N: per-channel mode, bits [2i+1:2i] for channel i (00 D, 01 T, 10 JK, 11 shift)
- `a` input N: per-channel primary input (D, T, J, or shift-in for channel 0)
- `b` input N: per-channel secondary input (K in JK mode; ignored otherwise)
- `pattern` input N: match pattern compared against the next-state Q
- `Q` output N: flip-flop states
- `mcnt` output CW: current consecutive-match count, saturating at HOLD
- `Z` output 1: match flag, `(mcnt == HOLD)`

## Operation

- Reset (`rst_n`=0): Q=0, mcnt=0, Z=0. Reset takes effect immediately and is independent of `clk`.
- On each rising edge with `rst_n`=1 and `en`=1, channel i computes Qn[i]:
  - 00 D: Qn[i]=a[i]
  - 01 T: Qn[i]=Q[i]^a[i]
  - 10 JK: a=J, b=K. 00 hold, 01 reset to 0, 10 set to 1, 11 toggle
  - 11 shift: Qn[i]=Q[i-1]; channel 0 takes a[0]. The source is the pre-edge Q[i-1] regardless of channel i-1's own mode.
- When `en`=0, Qn=Q for every channel.
- Match counter, updated every rising edge regardless of `en`:
  - If Qn==pattern, mcnt ← min(mcnt+1, HOLD).
  - Otherwise mcnt ← 0.
  - `pattern` is sampled at the same edge as Qn.
- `Z` is combinational from `mcnt` only. It has no direct input path and is glitch-free relative to `clk`.
- Arithmetic: the counter saturates, so it never wraps. CW bits hold HOLD exactly.

## Timing

- Q latency: one edge. Inputs set up before rising edge k appear on Q just after edge k.
- Z latency: Z rises just after the HOLD-th consecutive edge at which Qn==pattern. It falls just after the first non-matching edge.
- Benches drive inputs on the falling edge or at least 1 ns before the rising edge. Clock rises at 5, 15, 25 ns, and so on.
- Asserting reset mid-cycle clears Q, mcnt and Z within the same timestep, with no clock edge needed.
- Reset release is asynchronous. The first state update is the first rising edge seen with `rst_n`=1.
- Initial state equals reset state, so at t=1 ns all outputs read 0. Z=0 even if `pattern`=0, because mcnt starts at 0.
- Simultaneous events:
  - Changes to `mode` and `en` on the same edge use their sampled values.
  - A `pattern` change and a Q change on the same edge are compared as sampled values.
  - In a chain of shift channels, every channel moves exactly one position per edge, with no ripple.

## Test plan

Parameters for all scenarios: N=4, HOLD=3. Q bits are listed [3:0].

- **Reset and initial state.** Hold rst_n=0 from 0 to 2 ns. Expect Q=0000, mcnt=0, Z=0 at 1 ns. Later, with Q=1010, drop rst_n at 23 ns, off-edge. Expect Q=0000, Z=0 at 23 ns.
- **D mode and enable.** All D, en=1, a=1010. After the edge, Q=1010. Then set en=0, a=0101. After two edges, Q is still 1010.
- **T mode.** Start from Q=1010, all T, a=0011. Q goes 1001, then 1010.
- **JK mode.** Start from Q=0000, all JK, a=1100, b=1010. After one edge, Q=1100: ch3 toggle, ch2 set, ch1 reset, ch0 hold.
- **Shift and mixed modes.**
  - Start from Q=0001, all shift, a[0]=0. Q goes 0010, 0100, 1000, 0000.
  - Mixed case: mode={D,T,JK,shift}. Every channel updates per its own rule on one edge.
- **Match detector.** pattern=0110, D mode, a=0110.
  - mcnt goes 1, 2, 3 with Z=1 after the 3rd edge. It stays 3 with Z=1 on further edges, including while en=0.
  - Set a=0111. After the next edge, mcnt=0 and Z=0.
